// File: rtl/xps2_ctrl_pkg.sv
// Shared constants and types for the PS/2 keyboard receive controller.
// Register bit positions mirror the firmware header so software and RTL stay in step.
package xps2_ctrl_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam logic [7:0]  PS2_EXT_CODE  = 8'hE0;
    localparam logic [7:0]  PS2_BRK_CODE  = 8'hF0;
    localparam logic        PS2_DATA_ADDR = 1'b0;
    localparam logic        PS2_STAT_ADDR = 1'b1;
    localparam int unsigned PS2_VALID_BIT = 10;

    typedef enum logic [1:0] {StIdle, StRecv, StCheck, StPush} ps2_state_e;

    // Packed so that ext lands on bit 9 and brk on bit 8 of a DATA read.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_key_t;

    function automatic logic frame_ok(input logic [7:0] code, input logic par,
                                      input logic stop, input logic chk_par);
        return stop && (!chk_par || (^{code, par}));
    endfunction

endpackage

// File: rtl/xps2_fifo.sv
// Key FIFO for the PS/2 controller: synchronous, pop is applied before push when both
// occur in one cycle, so a push at full alongside a pop is accepted.
module xps2_fifo
    import xps2_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  ps2_key_t                 wdata,
    output ps2_key_t                 rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nxt,
    output logic                     dropped
);

    localparam int unsigned AW = $clog2(DEPTH);

    ps2_key_t        mem_q [DEPTH];
    ps2_key_t        mem_d [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     level_q, level_d;
    logic            do_pop, do_push;

    always_comb begin
        do_pop  = pop && (level_q != '0);
        do_push = push && ((level_q != (AW+1)'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign rdata     = mem_q[rptr_q];
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign level_nxt = level_d;
    assign dropped   = push && !do_push;

endmodule

// File: rtl/xps2_ctrl.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, frame FSM with
// E0/F0 prefix folding, key FIFO and the DATA/STATUS register read port.
module xps2_ctrl
    import xps2_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILT_CYC    = 8,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter bit          CHK_PARITY  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              sel,
    input  logic              rd,
    input  logic              addr,
    output logic [DATA_W-1:0] data_out,
    output logic              key_irq
);

    localparam int unsigned L   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW = $clog2(FILT_CYC + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]        pclk_sync_q, pclk_sync_d, pdat_sync_q, pdat_sync_d;
    logic              filt_q, filt_d;
    logic [FCW-1:0]    filt_cnt_q, filt_cnt_d;
    logic              fall, pdat;
    ps2_state_e        state_q, state_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [9:0]        shreg_q, shreg_d;
    logic [TCW-1:0]    tmo_q, tmo_d;
    logic              ext_q, ext_d, brk_q, brk_d;
    logic              ferr_q, ferr_d, ovf_q, ovf_d, ferr_set;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              irq_q, irq_d;
    logic              push, pop;
    ps2_key_t          fifo_wdata, fifo_rdata;
    logic              fifo_empty, fifo_dropped;
    logic [L:0]        level, level_nxt;

    // Synchronisers and filter: the filtered clock only follows after FILT_CYC
    // consecutive samples disagreeing with it.
    always_comb begin
        pclk_sync_d = {pclk_sync_q[0], ps2_clk};
        pdat_sync_d = {pdat_sync_q[0], ps2_data};
        pdat        = pdat_sync_q[1];
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        fall        = 1'b0;
        if (pclk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FCW'(FILT_CYC - 1)) begin
                filt_d = ~filt_q;
                fall   = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        tmo_d      = tmo_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        ferr_set   = 1'b0;
        push       = 1'b0;
        fifo_wdata = '{ext: ext_q, brk: brk_q, code: shreg_q[7:0]};
        unique case (state_q)
            StIdle: begin
                if (fall && !pdat) begin
                    state_d  = StRecv;
                    bitcnt_d = 4'd1;
                    tmo_d    = '0;
                end
            end
            StRecv: begin
                if (fall) begin
                    shreg_d  = {pdat, shreg_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    tmo_d    = '0;
                    if (bitcnt_q == 4'd10) begin
                        state_d = StCheck;
                    end
                end else if (tmo_q == TCW'(TIMEOUT_CYC - 1)) begin
                    ferr_set = 1'b1;
                    state_d  = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (!frame_ok(shreg_q[7:0], shreg_q[8], shreg_q[9], CHK_PARITY)) begin
                    ferr_set = 1'b1;
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                end else if (shreg_q[7:0] == PS2_EXT_CODE) begin
                    ext_d = 1'b1;
                end else if (shreg_q[7:0] == PS2_BRK_CODE) begin
                    brk_d = 1'b1;
                end else begin
                    state_d = StPush;
                end
            end
            StPush: begin
                push    = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Register port; status flags are sampled before the clear, and a same-cycle set wins.
    always_comb begin
        pop    = 1'b0;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        ferr_d = ferr_q;
        if (sel && rd) begin
            dout_d = '0;
            if (addr == PS2_DATA_ADDR) begin
                if (!fifo_empty) begin
                    pop                   = 1'b1;
                    dout_d[PS2_VALID_BIT] = 1'b1;
                    dout_d[9:0]           = fifo_rdata;
                end
            end else if (addr == PS2_STAT_ADDR) begin
                dout_d[L:0]   = level;
                dout_d[L+1]   = ferr_q;
                dout_d[L+2]   = ovf_q;
                ovf_d         = 1'b0;
                ferr_d        = 1'b0;
            end
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
        if (fifo_dropped) begin
            ovf_d = 1'b1;
        end
        irq_d = (level_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sync_q <= 2'b11;
            pdat_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= StIdle;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            ferr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dout_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            pclk_sync_q <= pclk_sync_d;
            pdat_sync_q <= pdat_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            ferr_q      <= ferr_d;
            ovf_q       <= ovf_d;
            dout_q      <= dout_d;
            irq_q       <= irq_d;
        end
    end

    xps2_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wdata    (fifo_wdata),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .level    (level),
        .level_nxt(level_nxt),
        .dropped  (fifo_dropped)
    );

    assign data_out = dout_q;
    assign key_irq  = irq_q;

endmodule

// File: tb/tb_xps2_ctrl.sv
// Bench for xps2_ctrl: frame/read stimulus feeds a queue-based key model and a scoreboard;
// a monitor compares data_out/key_irq after every register read or peek request.
module tb_xps2_ctrl;

    localparam int DEPTH = 8;
    localparam int L     = $clog2(DEPTH);
    localparam int HALF  = 50;  // PS/2 half period in clk cycles, scaled down for run time

    typedef struct {
        string       nm;
        bit          b;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rd, addr, sel_a, sel_b;
    logic        pclk, pdat, tgt;
    logic        peek, peek_b, fin;
    logic [31:0] dout_a, dout_b;
    logic        irq_a, irq_b;
    wire         pclk_a = tgt ? 1'b1 : pclk;
    wire         pdat_a = tgt ? 1'b1 : pdat;
    wire         pclk_b = tgt ? pclk : 1'b1;
    wire         pdat_b = tgt ? pdat : 1'b1;

    exp_t        sb[$];
    logic [31:0] mq_a[$];
    logic [31:0] mq_b[$];
    bit          ovf_m[2], ferr_m[2], ext_m[2], brk_m[2];
    logic [31:0] last_m[2];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_b;
    exp_t        ex;

    always #5 clk = ~clk;

    xps2_ctrl #(.FIFO_DEPTH(DEPTH), .FILT_CYC(8), .TIMEOUT_CYC(4096), .CHK_PARITY(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ps2_clk(pclk_a), .ps2_data(pdat_a), .sel(sel_a), .rd(rd),
        .addr(addr), .data_out(dout_a), .key_irq(irq_a)
    );

    xps2_ctrl #(.FIFO_DEPTH(DEPTH), .FILT_CYC(8), .TIMEOUT_CYC(4096), .CHK_PARITY(1'b0)) u_np (
        .clk(clk), .rst(rst), .ps2_clk(pclk_b), .ps2_data(pdat_b), .sel(sel_b), .rd(rd),
        .addr(addr), .data_out(dout_b), .key_irq(irq_b)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: sole owner of the counters.
    always @(posedge clk) begin
        if (fin) begin
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end else if (peek || (rd && (sel_a || sel_b))) begin
            mon_b = peek ? peek_b : sel_b;
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got an unexpected read, expected none");
            end else begin
                ex = sb.pop_front();
                chk({ex.nm, ".data"}, mon_b ? dout_b : dout_a, ex.dout);
                chk({ex.nm, ".irq"}, {31'b0, mon_b ? irq_b : irq_a}, {31'b0, ex.irq});
            end
        end
    end

    function automatic int mlevel(input bit b);
        return b ? mq_b.size() : mq_a.size();
    endfunction

    function automatic void model_reset();
        mq_a.delete();
        mq_b.delete();
        for (int i = 0; i < 2; i++) begin
            ovf_m[i] = 0; ferr_m[i] = 0; ext_m[i] = 0; brk_m[i] = 0; last_m[i] = '0;
        end
    endfunction

    function automatic void model_frame(input bit b, input logic [7:0] code, input bit bad);
        logic [31:0] e;
        if (bad && !b) begin
            ferr_m[b] = 1; ext_m[b] = 0; brk_m[b] = 0;
        end else if (code == 8'hE0) begin
            ext_m[b] = 1;
        end else if (code == 8'hF0) begin
            brk_m[b] = 1;
        end else begin
            e = {21'b0, 1'b1, ext_m[b], brk_m[b], code};
            if (mlevel(b) >= DEPTH) ovf_m[b] = 1;
            else if (b) mq_b.push_back(e);
            else mq_a.push_back(e);
            ext_m[b] = 0; brk_m[b] = 0;
        end
    endfunction

    task automatic read_reg(input bit b, input bit a, input string nm);
        exp_t        x;
        logic [31:0] e;
        e = '0;
        if (!a) begin
            if (mlevel(b) != 0) e = b ? mq_b.pop_front() : mq_a.pop_front();
        end else begin
            e[L:0] = (L+1)'(mlevel(b));
            e[L+1] = ferr_m[b];
            e[L+2] = ovf_m[b];
            ferr_m[b] = 0;
            ovf_m[b]  = 0;
        end
        last_m[b] = e;
        x.nm = nm; x.b = b; x.dout = e; x.irq = (mlevel(b) != 0);
        sb.push_back(x);
        addr = a; rd = 1'b1;
        if (b) sel_b = 1'b1; else sel_a = 1'b1;
        @(negedge clk);
        rd = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
    endtask

    task automatic do_peek(input bit b, input string nm);
        exp_t x;
        x.nm = nm; x.b = b; x.dout = last_m[b]; x.irq = (mlevel(b) != 0);
        sb.push_back(x);
        peek = 1'b1; peek_b = b;
        @(negedge clk);
        peek = 1'b0;
    endtask

    // nbits < 11 sends a truncated frame; the model is updated only for full frames.
    task automatic send_frame(input bit b, input logic [7:0] code, input bit bad_par,
                              input int nbits, input bit pop_at_push);
        logic [10:0] bits;
        bits = {1'b1, ~(^code) ^ bad_par, code, 1'b0};
        tgt  = b;
        for (int i = 0; i < nbits; i++) begin
            pdat = bits[i];
            repeat (HALF) @(negedge clk);
            pclk = 1'b0;
            if (pop_at_push && i == 10) begin
                // Lands the DATA read on the cycle the FSM spends in PUSH.
                repeat (11) @(negedge clk);
                read_reg(b, 1'b0, "pop_at_push");
                repeat (HALF - 12) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            pclk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        pdat = 1'b1;
        tgt  = 1'b0;
        if (nbits == 11) model_frame(b, code, bad_par);
    endtask

    initial begin
        logic [7:0] code;
        int         r;
        bit         bad;
        rst = 1'b1; rd = 1'b0; addr = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
        pclk = 1'b1; pdat = 1'b1; tgt = 1'b0; peek = 1'b0; peek_b = 1'b0; fin = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        do_peek(0, "reset_a");
        do_peek(1, "reset_b");
        read_reg(0, 1'b1, "reset_status");

        // Single key, plus rd without sel doing nothing.
        send_frame(0, 8'h69, 0, 11, 0);
        do_peek(0, "t1_irq");
        addr = 1'b0; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        do_peek(0, "t1_rd_nosel");
        read_reg(0, 1'b0, "t1_data");
        read_reg(0, 1'b1, "t1_status");

        // Prefix folding.
        send_frame(0, 8'hE0, 0, 11, 0);
        send_frame(0, 8'hF0, 0, 11, 0);
        send_frame(0, 8'h75, 0, 11, 0);
        read_reg(0, 1'b1, "t2_status");
        read_reg(0, 1'b0, "t2_data_ext_brk");
        send_frame(0, 8'h75, 0, 11, 0);
        read_reg(0, 1'b0, "t2_data_plain");

        // Parity error, with and without checking.
        send_frame(0, 8'h79, 1, 11, 0);
        read_reg(0, 1'b1, "t3_status_err");
        read_reg(0, 1'b1, "t3_status_clr");
        send_frame(1, 8'h79, 1, 11, 0);
        read_reg(1, 1'b0, "t3_nopar_data");

        // Receive timeout.
        send_frame(0, 8'h33, 0, 5, 0);
        repeat (4200) @(negedge clk);
        ferr_m[0] = 1;
        read_reg(0, 1'b1, "t4_status_tmo");
        send_frame(0, 8'h5A, 0, 11, 0);
        read_reg(0, 1'b0, "t4_data");

        // Overflow, ordering, empty read, then pop coincident with PUSH at full.
        for (int i = 0; i < 9; i++) send_frame(0, 8'h10 + 8'(i), 0, 11, 0);
        read_reg(0, 1'b1, "t5_status_ovf");
        for (int i = 0; i < 9; i++) read_reg(0, 1'b0, "t5_drain");
        for (int i = 0; i < 8; i++) send_frame(0, 8'h20 + 8'(i), 0, 11, 0);
        send_frame(0, 8'h30, 0, 11, 1);
        read_reg(0, 1'b1, "t5_status_full");
        for (int i = 0; i < 8; i++) read_reg(0, 1'b0, "t5_drain2");

        // Reset mid-frame, then a filter glitch with data low.
        send_frame(0, 8'h12, 0, 11, 0);
        send_frame(0, 8'h7B, 0, 4, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_peek(0, "t6_after_rst");
        pdat = 1'b0;
        @(negedge clk);
        pclk = 1'b0;
        @(negedge clk);
        pclk = 1'b1;
        repeat (20) @(negedge clk);
        pdat = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(0, 8'h7B, 0, 11, 0);
        read_reg(0, 1'b0, "t6_data");
        read_reg(0, 1'b0, "t6_empty");
        read_reg(0, 1'b1, "t6_status");

        // Randomised frames and reads.
        for (int i = 0; i < 12; i++) begin
            code = 8'($urandom_range(0, 255));
            r    = $urandom_range(0, 9);
            if (r == 0) code = 8'hE0;
            if (r == 1) code = 8'hF0;
            bad  = ($urandom_range(0, 7) == 0);
            send_frame(0, code, bad, 11, 0);
            if ($urandom_range(0, 2) == 0) read_reg(0, 1'($urandom_range(0, 1)), "rnd_read");
        end
        read_reg(0, 1'b1, "rnd_status");
        while (mq_a.size() != 0) read_reg(0, 1'b0, "rnd_drain");
        read_reg(0, 1'b0, "rnd_empty");

        repeat (5) @(negedge clk);
        fin = 1'b1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
